// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles little-endian words from a valid/ready byte link
// and writes them to the instruction memory from address 0, keeping a wrapping checksum.
module imem_loader #(
    parameter int DEPTH = 64
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Start,
    input  logic [6:0]               Length,
    input  logic [7:0]               Byte_in,
    input  logic                     Byte_valid,
    output logic                     Byte_ready,
    output logic                     WE,
    output logic [$clog2(DEPTH)-1:0] WAddr,
    output logic [31:0]              WData,
    output logic                     Busy,
    output logic                     Done,
    output logic [31:0]              Sum
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [6:0] DEPTH_L = 7'(DEPTH);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t      state;
    logic [6:0]  target;
    logic [6:0]  cnt;
    logic [1:0]  bidx;
    logic [23:0] asm_r;
    logic [6:0]  tgt_clamped;
    logic [6:0]  cnt_inc;

    always_comb begin
        tgt_clamped = (Length > DEPTH_L) ? DEPTH_L : Length;
        cnt_inc     = cnt + 7'd1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            target     <= '0;
            cnt        <= '0;
            bidx       <= '0;
            asm_r      <= '0;
            Byte_ready <= 1'b0;
            WE         <= 1'b0;
            WAddr      <= '0;
            WData      <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Sum        <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        target <= tgt_clamped;
                        cnt    <= '0;
                        bidx   <= '0;
                        Sum    <= '0;
                        WAddr  <= '0;
                        if (tgt_clamped == 7'd0) begin
                            state      <= DONE;
                            Done       <= 1'b1;
                            Busy       <= 1'b0;
                            Byte_ready <= 1'b0;
                        end else begin
                            state      <= RECV;
                            Done       <= 1'b0;
                            Busy       <= 1'b1;
                            Byte_ready <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (Byte_valid) begin
                        case (bidx)
                            2'd0: asm_r[7:0]   <= Byte_in;
                            2'd1: asm_r[15:8]  <= Byte_in;
                            2'd2: asm_r[23:16] <= Byte_in;
                            default: begin
                                WData      <= {Byte_in, asm_r};
                                WE         <= 1'b1;
                                Byte_ready <= 1'b0;
                                state      <= WRITE;
                            end
                        endcase
                        bidx <= bidx + 2'd1;
                    end
                end
                WRITE: begin
                    // Checksum and address advance as the write cycle closes.
                    WE    <= 1'b0;
                    Sum   <= Sum + WData;
                    cnt   <= cnt_inc;
                    WAddr <= cnt_inc[AW-1:0];
                    if (cnt_inc == target) begin
                        state <= DONE;
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                    end else begin
                        state      <= RECV;
                        Byte_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized loads checked against a
// byte-stream reference model (little-endian word assembly, clamped length, wrapping sum).
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  length = '0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        we;
    logic [5:0]  waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] sum;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  tx[$];
    logic [5:0]  we_addr_q[$];
    logic [31:0] we_data_q[$];
    int          we_bad = 0;

    imem_loader #(.DEPTH(64)) dut (
        .CLK(clk), .RST(rst), .Start(start), .Length(length),
        .Byte_in(byte_in), .Byte_valid(byte_valid), .Byte_ready(byte_ready),
        .WE(we), .WAddr(waddr), .WData(wdata), .Busy(busy), .Done(done), .Sum(sum)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we) begin
            we_addr_q.push_back(waddr);
            we_data_q.push_back(wdata);
            if (byte_ready || !busy) we_bad++;
        end
    end

    task automatic send_all(input int maxgap);
        for (int i = 0; i < tx.size(); i++) begin
            int gap;
            int budget;
            gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            if (gap > 0) begin
                byte_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            byte_in = tx[i];
            byte_valid = 1'b1;
            budget = 0;
            while (!byte_ready && budget < 20) begin
                @(negedge clk);
                budget++;
            end
            if (!byte_ready) begin
                vectors++; miscompares++;
                $display("FAIL send_timeout: byte %0d not accepted, Byte_ready=%b required 1", i, byte_ready);
                byte_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        byte_valid = 1'b0;
    endtask

    // Runs one load of 'len' words using the bytes in tx and checks against the model.
    task automatic run_load(input int len, input int maxgap, input bit pre_valid);
        int n;
        logic [31:0] w;
        logic [31:0] exp_sum;
        n = (len > 64) ? 64 : len;
        we_addr_q.delete();
        we_data_q.delete();
        we_bad = 0;
        if (pre_valid && tx.size() > 0) begin
            byte_in = tx[0];
            byte_valid = 1'b1;
        end
        start = 1'b1;
        length = 7'(len);
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (byte_ready !== (n > 0) || busy !== (n > 0) || done !== (n == 0)) begin
            miscompares++;
            $display("FAIL start_latency: ready=%b busy=%b done=%b required ready=%b busy=%b done=%b",
                     byte_ready, busy, done, n > 0, n > 0, n == 0);
        end
        if (n > 0) begin
            send_all(maxgap);
            vectors++;
            if (we !== 1'b1 || waddr !== 6'(n - 1)) begin
                miscompares++;
                $display("FAIL we_latency: WE=%b WAddr=%0d required WE=1 WAddr=%0d", we, waddr, n - 1);
            end
            @(negedge clk);
        end else begin
            repeat (3) @(negedge clk);
        end
        exp_sum = '0;
        for (int i = 0; i < n; i++) begin
            w = {tx[4*i+3], tx[4*i+2], tx[4*i+1], tx[4*i]};
            exp_sum += w;
            vectors++;
            if (i >= we_data_q.size() || we_addr_q[i] !== 6'(i) || we_data_q[i] !== w) begin
                miscompares++;
                $display("FAIL write_%0d: got addr/data %0d/%h required %0d/%h", i,
                         (i < we_addr_q.size()) ? we_addr_q[i] : 6'h3f,
                         (i < we_data_q.size()) ? we_data_q[i] : 32'hx, i, w);
            end
        end
        vectors++;
        if (we_data_q.size() != n || we_bad != 0) begin
            miscompares++;
            $display("FAIL we_count: %0d pulses (%0d with ready/!busy) required %0d (0)",
                     we_data_q.size(), we_bad, n);
        end
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || byte_ready !== 1'b0 || we !== 1'b0) begin
            miscompares++;
            $display("FAIL done_state: done=%b busy=%b ready=%b we=%b required 1 0 0 0",
                     done, busy, byte_ready, we);
        end
        vectors++;
        if (sum !== exp_sum) begin
            miscompares++;
            $display("FAIL sum: got %h required %h", sum, exp_sum);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({byte_ready, we, waddr, wdata, busy, done, sum} !== '0) begin
            miscompares++;
            $display("FAIL reset: ready=%b we=%b waddr=%0d wdata=%h busy=%b done=%b sum=%h required all 0",
                     byte_ready, we, waddr, wdata, busy, done, sum);
        end
    endtask

    task automatic test_single_word();
        tx = '{8'h13, 8'h00, 8'h50, 8'h00};
        run_load(1, 0, 1'b1);
        vectors++;
        if (we_data_q.size() != 1 || we_data_q[0] !== 32'h00500013 || sum !== 32'h00500013) begin
            miscompares++;
            $display("FAIL single_word: sum=%h writes=%0d required 00500013 and 1 write", sum, we_data_q.size());
        end
    endtask

    task automatic test_stalls();
        tx = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h01, 8'h00, 8'h00, 8'h00};
        run_load(2, 3, 1'b0);
        vectors++;
        if (sum !== 32'hDEADBEF0) begin
            miscompares++;
            $display("FAIL stalls_sum: got %h required DEADBEF0", sum);
        end
    endtask

    task automatic test_clamp_full();
        tx.delete();
        for (int i = 0; i < 64; i++) begin
            tx.push_back(8'(i));
            tx.push_back(8'h00);
            tx.push_back(8'h00);
            tx.push_back(8'h00);
        end
        run_load(100, 0, 1'b0);
        vectors++;
        if (sum !== 32'h000007E0) begin
            miscompares++;
            $display("FAIL clamp_sum: got %h required 000007E0", sum);
        end
        byte_in = 8'hAA;
        byte_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++;
            if (byte_ready !== 1'b0 || we !== 1'b0 || done !== 1'b1) begin
                miscompares++;
                $display("FAIL extra_byte: ready=%b we=%b done=%b required 0 0 1", byte_ready, we, done);
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic test_zero_length();
        tx.delete();
        run_load(0, 0, 1'b0);
    endtask

    task automatic test_abort_restart();
        logic [31:0] w0;
        tx.delete();
        for (int i = 0; i < 5; i++) tx.push_back(8'($urandom));
        w0 = {tx[3], tx[2], tx[1], tx[0]};
        we_addr_q.delete();
        we_data_q.delete();
        start = 1'b1;
        length = 7'd3;
        @(negedge clk);
        start = 1'b0;
        send_all(1);
        start = 1'b1;
        length = 7'd1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || byte_ready !== 1'b1 || waddr !== 6'd1 || sum !== w0) begin
            miscompares++;
            $display("FAIL start_ignored: busy=%b ready=%b waddr=%0d sum=%h required 1 1 1 %h",
                     busy, byte_ready, waddr, sum, w0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({byte_ready, we, waddr, busy, done, sum} !== '0) begin
            miscompares++;
            $display("FAIL abort_state: ready=%b we=%b waddr=%0d busy=%b done=%b sum=%h required all 0",
                     byte_ready, we, waddr, busy, done, sum);
        end
        byte_in = 8'h55;
        byte_valid = 1'b1;
        repeat (6) @(negedge clk);
        byte_valid = 1'b0;
        vectors++;
        if (we_addr_q.size() != 1 || we_addr_q[0] !== 6'd0 || we_data_q[0] !== w0) begin
            miscompares++;
            $display("FAIL abort_writes: %0d writes required exactly 1 at addr 0 data %h", we_addr_q.size(), w0);
        end
        tx.delete();
        for (int i = 0; i < 4; i++) tx.push_back(8'($urandom));
        run_load(1, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int len;
            int n;
            len = int'($urandom_range(80, 0));
            n = (len > 64) ? 64 : len;
            tx.delete();
            for (int i = 0; i < 4 * n; i++) tx.push_back(8'($urandom));
            run_load(len, 2, 1'($urandom));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_word();
        test_stalls();
        test_clamp_full();
        test_zero_length();
        test_abort_restart();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
